// File: rtl/aq_apb_clken_pkg.sv
// Shared types and constants for the clock-enable qualified APB master.
package aq_apb_clken_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ACCESS = 3'd3,
        ST_RESP   = 3'd4
    } apb_state_e;

    localparam int unsigned TMO_W_DEF = 8;

    // Terminal count of the pready-wait counter for a given counter width.
    function automatic int unsigned tmo_limit(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/aq_apb_clken_tmo.sv
// Pready-wait timeout counter; clear/increment take effect only on APB edges.
module aq_apb_clken_tmo
    import aq_apb_clken_pkg::*;
#(
    parameter int unsigned TMO_W = TMO_W_DEF
) (
    input  logic forever_cpuclk,
    input  logic clkgen_rst_b,
    input  logic apb_clk_en,
    input  logic clr,
    input  logic inc,
    output logic hit
);

    localparam logic [TMO_W-1:0] LIMIT = TMO_W'(tmo_limit(TMO_W));

    logic [TMO_W-1:0] cnt_q;

    always_ff @(posedge forever_cpuclk or negedge clkgen_rst_b) begin
        if (!clkgen_rst_b) begin
            cnt_q <= '0;
        end else if (apb_clk_en) begin
            if (clr) begin
                cnt_q <= '0;
            end else if (inc) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign hit = (cnt_q == LIMIT);

endmodule

// File: rtl/aq_apb_clken_master.sv
// Single-outstanding APB master on the core clock; APB-facing state advances
// only on cycles qualified by apb_clk_en.
module aq_apb_clken_master
    import aq_apb_clken_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TMO_W  = TMO_W_DEF
) (
    input  logic                  forever_cpuclk,
    input  logic                  clkgen_rst_b,
    input  logic                  apb_clk_en,
    input  logic                  cpu_req_vld,
    output logic                  cpu_req_rdy,
    input  logic                  cpu_req_write,
    input  logic [ADDR_W-1:0]     cpu_req_addr,
    input  logic [DATA_W-1:0]     cpu_req_wdata,
    input  logic [DATA_W/8-1:0]   cpu_req_wstrb,
    output logic                  cpu_rsp_vld,
    input  logic                  cpu_rsp_rdy,
    output logic [DATA_W-1:0]     cpu_rsp_rdata,
    output logic                  cpu_rsp_err,
    output logic                  cpu_rsp_tmo,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_W-1:0]     paddr,
    output logic [DATA_W-1:0]     pwdata,
    output logic [DATA_W/8-1:0]   pstrb,
    input  logic [DATA_W-1:0]     prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    localparam int unsigned STRB_W = DATA_W / 8;

    apb_state_e          state_q, state_d;
    logic                req_write_q;
    logic [ADDR_W-1:0]   req_addr_q;
    logic [DATA_W-1:0]   req_wdata_q;
    logic [STRB_W-1:0]   req_wstrb_q;
    logic                psel_q, psel_d, penable_q, penable_d;
    logic                pwrite_q;
    logic [ADDR_W-1:0]   paddr_q;
    logic [DATA_W-1:0]   pwdata_q;
    logic [STRB_W-1:0]   pstrb_q;
    logic                rsp_vld_q, rsp_err_q, rsp_tmo_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                ld_req, drive_apb, rsp_ld, rsp_clr;
    logic                tmo_clr, tmo_inc, tmo_hit;
    logic [DATA_W-1:0]   rsp_rdata_d;
    logic                rsp_err_d, rsp_tmo_d;

    aq_apb_clken_tmo #(.TMO_W(TMO_W)) u_tmo (
        .forever_cpuclk (forever_cpuclk),
        .clkgen_rst_b   (clkgen_rst_b),
        .apb_clk_en     (apb_clk_en),
        .clr            (tmo_clr),
        .inc            (tmo_inc),
        .hit            (tmo_hit)
    );

    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        ld_req      = 1'b0;
        drive_apb   = 1'b0;
        rsp_ld      = 1'b0;
        rsp_clr     = 1'b0;
        tmo_clr     = 1'b0;
        tmo_inc     = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        rsp_tmo_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cpu_req_vld) begin
                    ld_req  = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (apb_clk_en) begin
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    drive_apb = 1'b1;
                    state_d   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (apb_clk_en) begin
                    penable_d = 1'b1;
                    tmo_clr   = 1'b1;
                    state_d   = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (apb_clk_en) begin
                    if (pready) begin
                        psel_d      = 1'b0;
                        penable_d   = 1'b0;
                        rsp_ld      = 1'b1;
                        rsp_rdata_d = req_write_q ? '0 : prdata;
                        rsp_err_d   = pslverr;
                        state_d     = ST_RESP;
                    end else if (tmo_hit) begin
                        psel_d    = 1'b0;
                        penable_d = 1'b0;
                        rsp_ld    = 1'b1;
                        rsp_err_d = 1'b1;
                        rsp_tmo_d = 1'b1;
                        state_d   = ST_RESP;
                    end else begin
                        tmo_inc = 1'b1;
                    end
                end
            end
            ST_RESP: begin
                if (cpu_rsp_rdy) begin
                    rsp_clr = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge forever_cpuclk or negedge clkgen_rst_b) begin
        if (!clkgen_rst_b) begin
            state_q     <= ST_IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            req_write_q <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_wstrb_q <= '0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            rsp_vld_q   <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_tmo_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            if (ld_req) begin
                req_write_q <= cpu_req_write;
                req_addr_q  <= cpu_req_addr;
                req_wdata_q <= cpu_req_wdata;
                req_wstrb_q <= cpu_req_write ? cpu_req_wstrb : '0;
            end
            if (drive_apb) begin
                pwrite_q <= req_write_q;
                paddr_q  <= req_addr_q;
                pwdata_q <= req_wdata_q;
                pstrb_q  <= req_wstrb_q;
            end
            if (rsp_ld) begin
                rsp_vld_q   <= 1'b1;
                rsp_rdata_q <= rsp_rdata_d;
                rsp_err_q   <= rsp_err_d;
                rsp_tmo_q   <= rsp_tmo_d;
            end else if (rsp_clr) begin
                rsp_vld_q <= 1'b0;
            end
        end
    end

    assign cpu_req_rdy   = (state_q == ST_IDLE);
    assign cpu_rsp_vld   = rsp_vld_q;
    assign cpu_rsp_rdata = rsp_rdata_q;
    assign cpu_rsp_err   = rsp_err_q;
    assign cpu_rsp_tmo   = rsp_tmo_q;
    assign psel          = psel_q;
    assign penable       = penable_q;
    assign pwrite        = pwrite_q;
    assign paddr         = paddr_q;
    assign pwdata        = pwdata_q;
    assign pstrb         = pstrb_q;

endmodule

// File: tb/tb_aq_apb_clken_master.sv
// Randomized bench for aq_apb_clken_master; expectations come from counting APB edges since accept.
module tb_aq_apb_clken_master;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int TMO_W  = 8;
    localparam int LIMIT  = (1 << TMO_W) - 1;
    localparam int BUDGET = 3000;

    logic        forever_cpuclk = 1'b0;
    logic        clkgen_rst_b;
    logic        apb_clk_en;
    logic        cpu_req_vld, cpu_req_rdy, cpu_req_write;
    logic [31:0] cpu_req_addr, cpu_req_wdata;
    logic [3:0]  cpu_req_wstrb;
    logic        cpu_rsp_vld, cpu_rsp_rdy, cpu_rsp_err, cpu_rsp_tmo;
    logic [31:0] cpu_rsp_rdata;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata, prdata;
    logic [3:0]  pstrb;
    logic        pready, pslverr;

    int checks = 0;
    int errors = 0;
    int en_mode = 0;   // 0: constant 1, 1: alternating, 2: random

    always #5 forever_cpuclk = ~forever_cpuclk;

    aq_apb_clken_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TMO_W(TMO_W)) dut (
        .forever_cpuclk (forever_cpuclk),
        .clkgen_rst_b   (clkgen_rst_b),
        .apb_clk_en     (apb_clk_en),
        .cpu_req_vld    (cpu_req_vld),
        .cpu_req_rdy    (cpu_req_rdy),
        .cpu_req_write  (cpu_req_write),
        .cpu_req_addr   (cpu_req_addr),
        .cpu_req_wdata  (cpu_req_wdata),
        .cpu_req_wstrb  (cpu_req_wstrb),
        .cpu_rsp_vld    (cpu_rsp_vld),
        .cpu_rsp_rdy    (cpu_rsp_rdy),
        .cpu_rsp_rdata  (cpu_rsp_rdata),
        .cpu_rsp_err    (cpu_rsp_err),
        .cpu_rsp_tmo    (cpu_rsp_tmo),
        .psel           (psel),
        .penable        (penable),
        .pwrite         (pwrite),
        .paddr          (paddr),
        .pwdata         (pwdata),
        .pstrb          (pstrb),
        .prdata         (prdata),
        .pready         (pready),
        .pslverr        (pslverr)
    );

    task automatic tick();
        @(posedge forever_cpuclk);
        #1;
        case (en_mode)
            0:       apb_clk_en = 1'b1;
            1:       apb_clk_en = ~apb_clk_en;
            default: apb_clk_en = 1'($urandom_range(0, 1));
        endcase
    endtask

    // One complete transfer. rdly = pready=0 samples in ACCESS before pready=1;
    // rdly > LIMIT means pready never comes and the transfer must time out.
    task automatic run_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, input logic [31:0] rdat, input logic serr,
                            input int rdly, input int hold, output int lat);
        int          done, n, held, cyc;
        logic        tmo_exp, got_rsp, en_now, hs;
        logic        exp_psel, exp_pen, exp_rspv;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_strb;
        tmo_exp   = (rdly > LIMIT);
        done      = tmo_exp ? (2 + LIMIT + 1) : (3 + rdly);
        exp_rdata = (wr || tmo_exp) ? 32'h0 : rdat;
        exp_strb  = wr ? strb : 4'h0;
        lat       = -1;
        checks++;
        if (cpu_req_rdy !== 1'b1) begin
            errors++;
            $display("FAIL accept_rdy: got %b exp 1", cpu_req_rdy);
        end
        cpu_req_vld   = 1'b1;
        cpu_req_write = wr;
        cpu_req_addr  = addr;
        cpu_req_wdata = wdata;
        cpu_req_wstrb = strb;
        cpu_rsp_rdy   = 1'b0;
        pready        = 1'($urandom_range(0, 1));
        pslverr       = 1'($urandom_range(0, 1));
        prdata        = $urandom;
        tick();
        cpu_req_vld   = 1'b0;
        cpu_req_write = 1'($urandom_range(0, 1));
        cpu_req_addr  = $urandom;
        cpu_req_wdata = $urandom;
        cpu_req_wstrb = 4'($urandom);
        checks++;
        if ({psel, penable, cpu_rsp_vld, cpu_req_rdy} !== 4'b0000) begin
            errors++;
            $display("FAIL after_accept ctrl(psel,pen,rspv,rdy): got %b exp 0000",
                     {psel, penable, cpu_rsp_vld, cpu_req_rdy});
        end
        n = 0; cyc = 0; held = 0; got_rsp = 1'b0;
        while (1) begin
            if (cyc >= BUDGET) begin
                checks++; errors++;
                $display("FAIL xfer_budget: no completion within %0d cycles", BUDGET);
                cpu_rsp_rdy = 1'b0;
                return;
            end
            if (apb_clk_en && (n + 1 >= 3) && (n + 1 <= done)) begin
                pready  = (n + 1 == done) && !tmo_exp;
                prdata  = (n + 1 == done) ? rdat : $urandom;
                pslverr = (n + 1 == done) ? serr : 1'($urandom_range(0, 1));
            end else begin
                pready  = 1'($urandom_range(0, 1));
                prdata  = $urandom;
                pslverr = 1'($urandom_range(0, 1));
            end
            if (got_rsp && held >= hold) cpu_rsp_rdy = 1'b1;
            en_now = apb_clk_en;
            hs     = got_rsp && cpu_rsp_rdy;
            tick();
            cyc++;
            if (en_now && n < done) n++;
            if (hs) begin
                checks++;
                if ({psel, penable, cpu_rsp_vld, cpu_req_rdy} !== 4'b0001) begin
                    errors++;
                    $display("FAIL handshake ctrl(psel,pen,rspv,rdy): got %b exp 0001",
                             {psel, penable, cpu_rsp_vld, cpu_req_rdy});
                end
                cpu_rsp_rdy = 1'b0;
                return;
            end
            exp_psel = (n >= 1) && (n < done);
            exp_pen  = (n >= 2) && (n < done);
            exp_rspv = (n >= done);
            checks++;
            if ({psel, penable, cpu_rsp_vld, cpu_req_rdy} !== {exp_psel, exp_pen, exp_rspv, 1'b0}) begin
                errors++;
                $display("FAIL ctrl(psel,pen,rspv,rdy) cyc %0d: got %b exp %b", cyc,
                         {psel, penable, cpu_rsp_vld, cpu_req_rdy}, {exp_psel, exp_pen, exp_rspv, 1'b0});
            end
            if (exp_psel) begin
                checks++;
                if ({paddr, pwrite, pwdata, pstrb} !== {addr, wr, wdata, exp_strb}) begin
                    errors++;
                    $display("FAIL apb_fields(addr,wr,wdata,strb): got %h %b %h %h exp %h %b %h %h",
                             paddr, pwrite, pwdata, pstrb, addr, wr, wdata, exp_strb);
                end
            end
            if (exp_rspv) begin
                checks++;
                if ({cpu_rsp_rdata, cpu_rsp_err, cpu_rsp_tmo} !== {exp_rdata, tmo_exp | serr, tmo_exp}) begin
                    errors++;
                    $display("FAIL rsp(rdata,err,tmo): got %h %b %b exp %h %b %b",
                             cpu_rsp_rdata, cpu_rsp_err, cpu_rsp_tmo, exp_rdata, tmo_exp | serr, tmo_exp);
                end
                if (!got_rsp) begin
                    got_rsp = 1'b1;
                    lat     = cyc;
                end else begin
                    held++;
                end
            end
        end
    endtask

    task automatic test_reset();
        clkgen_rst_b  = 1'b0;
        apb_clk_en    = 1'b0;
        cpu_req_vld   = 1'b0;
        cpu_req_write = 1'b0;
        cpu_req_addr  = '0;
        cpu_req_wdata = '0;
        cpu_req_wstrb = '0;
        cpu_rsp_rdy   = 1'b0;
        prdata        = '0;
        pready        = 1'b0;
        pslverr       = 1'b0;
        #3;
        checks++;
        if (cpu_req_rdy !== 1'b1) begin
            errors++;
            $display("FAIL reset_rdy: got %b exp 1", cpu_req_rdy);
        end
        checks++;
        if ({cpu_rsp_vld, cpu_rsp_rdata, cpu_rsp_err, cpu_rsp_tmo, psel, penable, pwrite, paddr, pwdata, pstrb} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rspv=%b rdata=%h err=%b tmo=%b psel=%b pen=%b pwr=%b paddr=%h pwdata=%h pstrb=%h exp all 0",
                     cpu_rsp_vld, cpu_rsp_rdata, cpu_rsp_err, cpu_rsp_tmo, psel, penable, pwrite, paddr, pwdata, pstrb);
        end
        #10;
        clkgen_rst_b = 1'b1;
        tick();
    endtask

    task automatic test_read_alt();
        int lat;
        en_mode = 1;
        run_xfer(1'b0, 32'h2000_0010, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0, 0, 0, lat);
        checks++;
        if (lat < 5 || lat > 6) begin
            errors++;
            $display("FAIL read_alt_latency: got %0d exp 5..6", lat);
        end
    endtask

    task automatic test_write_wait();
        int lat;
        en_mode = 1;
        run_xfer(1'b1, 32'h1000_0040, 32'h1234_5678, 4'h3, 32'hCAFE_F00D, 1'b0, 3, 0, lat);
    endtask

    task automatic test_slverr_hold();
        int lat;
        en_mode = 2;
        run_xfer(1'b0, 32'h3000_0000, 32'h0, 4'h0, 32'h5555_AAAA, 1'b1, 0, 4, lat);
    endtask

    task automatic test_timeout();
        int lat;
        en_mode = 2;
        run_xfer(1'b0, 32'h4000_0004, 32'h0, 4'h0, 32'h1111_2222, 1'b0, LIMIT + 1, 1, lat);
    endtask

    task automatic test_reset_access();
        int cyc;
        logic en_now;
        int n;
        en_mode = 1;
        cpu_req_vld   = 1'b1;
        cpu_req_write = 1'b0;
        cpu_req_addr  = 32'h5000_0008;
        pready        = 1'b0;
        tick();
        cpu_req_vld = 1'b0;
        n = 0; cyc = 0;
        while (n < 2 && cyc < 50) begin
            en_now = apb_clk_en;
            pready = 1'b0;
            tick();
            cyc++;
            if (en_now) n++;
        end
        checks++;
        if ({psel, penable} !== 2'b11) begin
            errors++;
            $display("FAIL rst_pre_access(psel,pen): got %b exp 11", {psel, penable});
        end
        #2 clkgen_rst_b = 1'b0;
        #1;
        checks++;
        if ({psel, penable, cpu_rsp_vld, cpu_req_rdy} !== 4'b0001) begin
            errors++;
            $display("FAIL rst_during_access ctrl(psel,pen,rspv,rdy): got %b exp 0001",
                     {psel, penable, cpu_rsp_vld, cpu_req_rdy});
        end
        checks++;
        if ({paddr, pwrite, pwdata, pstrb} !== '0) begin
            errors++;
            $display("FAIL rst_apb_regs: got paddr=%h pwr=%b pwdata=%h pstrb=%h exp 0",
                     paddr, pwrite, pwdata, pstrb);
        end
        #2 clkgen_rst_b = 1'b1;
        for (int i = 0; i < 10; i++) begin
            pready  = 1'($urandom_range(0, 1));
            pslverr = 1'($urandom_range(0, 1));
            tick();
            checks++;
            if ({psel, penable, cpu_rsp_vld, cpu_req_rdy} !== 4'b0001) begin
                errors++;
                $display("FAIL rst_after_release ctrl(psel,pen,rspv,rdy): got %b exp 0001",
                         {psel, penable, cpu_rsp_vld, cpu_req_rdy});
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        en_mode = 0;
        for (int i = 0; i < 2; i++) begin
            run_xfer(1'b0, 32'h6000_0000 + 32'(i * 4), 32'h0, 4'hF, $urandom, 1'b0, 0, 0, lat);
            checks++;
            if (lat !== 3) begin
                errors++;
                $display("FAIL b2b_latency[%0d]: got %0d exp 3", i, lat);
            end
        end
    endtask

    task automatic test_random();
        int lat;
        for (int i = 0; i < 20; i++) begin
            en_mode = $urandom_range(0, 2);
            run_xfer(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom), $urandom,
                     1'($urandom_range(0, 1)), $urandom_range(0, 5), $urandom_range(0, 3), lat);
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                tick();
                checks++;
                if ({psel, penable, cpu_rsp_vld, cpu_req_rdy} !== 4'b0001) begin
                    errors++;
                    $display("FAIL idle_gap ctrl(psel,pen,rspv,rdy): got %b exp 0001",
                             {psel, penable, cpu_rsp_vld, cpu_req_rdy});
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_read_alt();
        test_write_wait();
        test_slverr_hold();
        test_timeout();
        test_reset_access();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aq_apb_clken_master.md
# aq_apb_clken_master

Single-outstanding APB master that converts CPU-side requests into APB SETUP/ACCESS transfers. It runs entirely on the fast core clock and advances APB-facing state only on cycles qualified by the divided APB clock enable. It is the consuming end of the APB clock-enable pair and sits between the core's peripheral request path and the APB fabric clocked by the gated APB clock.

## Interface

Parameters:
- ADDR_W, 32, APB address width
- DATA_W, 32, APB data width; multiple of 8
- TMO_W, 8, width of the pready-wait timeout counter; limit = 2^TMO_W-1

Ports:
- forever_cpuclk  in  1  core clock; all flops
- clkgen_rst_b  in  1  asynchronous, active-low reset
- apb_clk_en  in  1  APB clock enable; a forever_cpuclk posedge with apb_clk_en=1 is an APB rising edge ("APB edge")
- cpu_req_vld  in  1  request valid
- cpu_req_rdy  out  1  request ready
- cpu_req_write  in  1  1=write, 0=read
- cpu_req_addr  in  ADDR_W  address
- cpu_req_wdata  in  DATA_W  write data
- cpu_req_wstrb  in  DATA_W/8  write byte strobes
- cpu_rsp_vld  out  1  response valid
- cpu_rsp_rdy  in  1  response ready
- cpu_rsp_rdata  out  DATA_W  read data; 0 for writes and timeouts
- cpu_rsp_err  out  1  pslverr or timeout
- cpu_rsp_tmo  out  1  timeout abort
- psel, penable, pwrite  out  1  APB control
- paddr  out  ADDR_W  APB address
- pwdata  out  DATA_W  APB write data
- pstrb  out  DATA_W/8  APB strobes
- prdata  in  DATA_W  APB read data
- pready, pslverr  in  1  APB completion and error

## Operation

- States: IDLE, WAIT, SETUP, ACCESS, RESP.
- cpu_req_rdy = (state==IDLE). This is combinational from the state only.
- IDLE: on cpu_req_vld && cpu_req_rdy, latch write, addr, wdata, and wstrb, then go to WAIT.
  - For reads, the latched strobe is forced to 0.
- WAIT: on the first APB edge strictly after the accept edge, set psel=1, penable=0, drive paddr/pwrite/pwdata/pstrb, and go to SETUP.
- SETUP: on the next APB edge, set penable=1, clear the timeout counter, and go to ACCESS.
- ACCESS is evaluated at each APB edge:
  - pready=1: clear psel and penable, and capture rdata (prdata if read, else 0). Set err=pslverr, tmo=0, rsp_vld=1, and go to RESP.
  - pready=0 and counter<limit: increment the counter.
  - pready=0 and counter==limit: clear psel and penable. Set rdata=0, err=1, tmo=1, rsp_vld=1, and go to RESP.
- Non-APB-edge cycles: all APB outputs and the state hold. The exception is IDLE→WAIT, which is CPU-side.
- RESP: hold the response until cpu_rsp_rdy=1, then rsp_vld=0 and go to IDLE.
  - This transition needs no apb_clk_en.
  - A new request can be accepted on the following cycle.
- paddr, pwrite, pwdata, and pstrb are stable from SETUP through the end of ACCESS.
- Reset (asynchronous at any point, including mid-transfer):
  - state=IDLE; psel, penable, rsp_vld, err, and tmo go to 0; all data/address registers go to 0.
  - No response is issued for the aborted transfer.
- pready/pslverr are ignored outside ACCESS.

## Timing

- Output reset values: cpu_req_rdy=1; every other output is 0.
- With apb_clk_en toggling 1-of-2 and pready=1 on the first ACCESS sample:
  - Accept edge T0.
  - SETUP at T0+1 or T0+2.
  - ACCESS 2 cycles later.
  - cpu_rsp_vld rises 2 cycles after ACCESS, i.e. T0+5 or T0+6.
- With apb_clk_en held at 1 (scan/1:1):
  - SETUP at T0+1, ACCESS at T0+2, rsp_vld at T0+3.
- Timeout fires on the (limit+1)-th consecutive pready=0 sample, i.e. the 256th at TMO_W=8.
- Throughput: one transfer in flight; there is no request buffering.

## Structure

- Shared package aq_apb_clken_pkg:
  - state enum (3-bit encoding for IDLE..RESP);
  - localparam for the timeout limit derived from TMO_W.
- One sub-module, aq_apb_clken_tmo:
  - TMO_W counter with inputs clr and inc (qualified by apb_clk_en) and output hit = (cnt==limit).
  - Clocked on forever_cpuclk with reset clkgen_rst_b.
- The top module holds the FSM, the request/response registers, and the APB output drive.

## Test plan

- Read, apb_clk_en alternating, pready=1 first sample, prdata=0xDEADBEEF:
  - psel at an APB edge, penable one APB edge later;
  - rsp_vld within 6 cycles with rdata=0xDEADBEEF, err=0.
- Write with addr=0x1000_0040, wdata=0x1234_5678, wstrb=0x3, pready delayed 3 APB edges:
  - pwrite=1 and pstrb=0x3 stable across the wait; rdata=0, err=0.
- Read with pslverr=1 and pready=1: err=1, tmo=0; rsp held while cpu_rsp_rdy=0 for 4 cycles, then released.
- pready stuck at 0, TMO_W=8: abort on the 256th ACCESS sample with err=1, tmo=1, psel=0 the same edge.
- Async reset asserted during ACCESS: psel/penable=0 immediately; cpu_req_rdy=1 after release; no rsp_vld.
- apb_clk_en=1 constant and back-to-back reads with cpu_rsp_rdy=1: rsp_vld at T0+3; the second request is accepted the cycle after the response handshake.
